// File: rtl/counter_pwm_gen_pkg.sv
// Shared types and reset constants for the PWM generator.
// Optional count-continuity checker is enabled with COUNT_CHECK_EN.
package pwm_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   localparam int unsigned ACTIVE_RST  = 0;
   localparam int unsigned PENDING_RST = 0;

endpackage

// File: rtl/counter_pwm_gen_if.sv
// Duty-update handshake: producer drives duty_in/duty_valid, PWM block drives duty_ready.
interface counter_pwm_gen_if #(
   parameter int N = 4
) ();

   logic [N-1:0] duty_in;
   logic         duty_valid;
   logic         duty_ready;

   modport master (
      output duty_in,
      output duty_valid,
      input  duty_ready
   );

   modport slave (
      input  duty_in,
      input  duty_valid,
      output duty_ready
   );

endinterface

// File: rtl/counter_pwm_gen_duty_buffer.sv
// One-entry pending duty buffer; the pending value moves to active only at period wrap,
// so the duty seen by the comparator never changes mid-period.
module duty_buffer
   import pwm_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wrap,
   input  logic [N-1:0] duty_in,
   input  logic         duty_valid,
   output logic [N-1:0] active,
   output logic         duty_ready
);

   buf_state_t   state;
   logic [N-1:0] pending;

   // duty_ready is a registered image of state == EMPTY, so it never depends on duty_valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= EMPTY;
         duty_ready <= 1'b1;
         pending    <= N'(PENDING_RST);
         active     <= N'(ACTIVE_RST);
      end else begin
         case (state)
            EMPTY: begin
               if (duty_valid && duty_ready) begin
                  pending    <= duty_in;
                  state      <= FULL;
                  duty_ready <= 1'b0;
               end
            end
            FULL: begin
               if (wrap) begin
                  active     <= pending;
                  state      <= EMPTY;
                  duty_ready <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/counter_pwm_gen.sv
// PWM generator driven by an external free-running N-bit up counter; period = 2^N cycles.
// Define COUNT_CHECK_EN to add the sticky count_err continuity checker.
module counter_pwm_gen
   import pwm_pkg::*;
#(
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N-1:0]       count,
   counter_pwm_gen_if.slave   dif,
   output logic               pwm_out,
`ifdef COUNT_CHECK_EN
   output logic               count_err,
`endif
   output logic               period_tick
);

   logic         wrap;
   logic [N-1:0] active;
   logic         ready;

   assign wrap           = (count == {N{1'b1}});
   assign dif.duty_ready = ready;

   duty_buffer #(.N(N)) u_duty_buffer (
      .clk        (clk),
      .reset_n    (reset_n),
      .wrap       (wrap),
      .duty_in    (dif.duty_in),
      .duty_valid (dif.duty_valid),
      .active     (active),
      .duty_ready (ready)
   );

   // active updates on the wrap edge, so count=0 of the next period already sees the new duty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_out     <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         pwm_out     <= (count < active);
         period_tick <= wrap;
      end
   end

`ifdef COUNT_CHECK_EN
   logic [N-1:0] prev_count;
   logic         seen;

   // The first post-reset sample only seeds prev_count; checking starts on the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_count <= '0;
         seen       <= 1'b0;
         count_err  <= 1'b0;
      end else begin
         prev_count <= count;
         seen       <= 1'b1;
         if (seen && (count != N'(prev_count + 1'b1)))
            count_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_counter_pwm_gen.sv
// Scoreboard bench for counter_pwm_gen: driver predicts per-cycle outputs into a queue,
// an independent monitor compares them one cycle later.
module tb_counter_pwm_gen;

   localparam int N = 4;
   localparam int P = 1 << N;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [N-1:0] count = '0;
   logic         pwm_out;
   logic         period_tick;
`ifdef COUNT_CHECK_EN
   logic         count_err;
`endif

   counter_pwm_gen_if #(.N(N)) dif ();

   counter_pwm_gen #(.N(N)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .count       (count),
      .dif         (dif),
      .pwm_out     (pwm_out),
`ifdef COUNT_CHECK_EN
      .count_err   (count_err),
`endif
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic pwm;
      logic tick;
      logic rdy;
   } exp_t;

   exp_t exp_q[$];
   int   pend_q[$];      // duty values accepted but not yet in force
   int   act_m = 0;      // duty in force for the current period
   int   cnt = 0;        // next count value to drive
   logic rst_drive = 1'b0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0b exp %0b at %0t", nm, a, e, $time);
      end
   endtask

   // Monitor: one expected entry per clock edge after the driver pushed it.
   exp_t m_e;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         chk("pwm_out", pwm_out, m_e.pwm);
         chk("period_tick", period_tick, m_e.tick);
         chk("duty_ready", dif.duty_ready, m_e.rdy);
      end
   end

   // One cycle of stimulus plus the model's prediction for the following edge.
   task automatic step(input logic v, input int d, output logic acc);
      exp_t e;
      @(negedge clk);
      reset_n        = rst_drive;
      count          = cnt[N-1:0];
      dif.duty_valid = v;
      dif.duty_in    = d[N-1:0];
      if (!reset_n) begin
         act_m = 0;
         pend_q.delete();
         acc   = 1'b0;
         e     = '{pwm: 1'b0, tick: 1'b0, rdy: 1'b1};
      end else begin
         acc    = v && (pend_q.size() == 0);
         e.pwm  = (cnt < act_m);
         e.tick = (cnt == P - 1);
         if (e.tick && pend_q.size() > 0) act_m = pend_q.pop_front();
         else if (acc) pend_q.push_back(d);
         e.rdy  = (pend_q.size() == 0);
      end
      exp_q.push_back(e);
      cnt = (cnt + 1) % P;
   endtask

   task automatic idle(input int n);
      logic a;
      repeat (n) step(1'b0, 0, a);
   endtask

   task automatic run_until(input int c);
      logic a;
      for (int i = 0; i < 2 * P && cnt != c; i++) step(1'b0, 0, a);
   endtask

   // Holds valid until the model sees the transfer; bounded so a stuck ready cannot hang the run.
   task automatic write(input int d);
      logic a;
      a = 1'b0;
      for (int i = 0; i < 3 * P && !a; i++) step(1'b1, d, a);
      if (!a) chk("write_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      dif.duty_valid = 1'b0;
      dif.duty_in    = '0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_pwm_out", pwm_out, 1'b0);
      chk("rst_period_tick", period_tick, 1'b0);
      chk("rst_duty_ready", dif.duty_ready, 1'b1);
      idle(2);
      rst_drive = 1'b1;
      idle(P);

      // duty=4 written at count 7
      run_until(7);
      write(4);
      idle(2 * P);

      // duty=0 then duty=15 on successive periods
      run_until(3);
      write(0);
      run_until(3);
      write(15);
      idle(2 * P);

      // back-to-back 3 then 9; 9 waits for ready
      run_until(2);
      write(3);
      write(9);
      idle(3 * P);

      // accept coinciding with wrap in EMPTY
      run_until(15);
      write(6);
      idle(3 * P);

      // async reset mid-period with a pending value
      run_until(5);
      write(10);
      idle(2);
      #2 reset_n = 1'b0;
      rst_drive = 1'b0;
      #1;
      chk("midrst_pwm_out", pwm_out, 1'b0);
      chk("midrst_period_tick", period_tick, 1'b0);
      chk("midrst_duty_ready", dif.duty_ready, 1'b1);
      exp_q.delete();
      pend_q.delete();
      act_m = 0;
      idle(2);
      rst_drive = 1'b1;
      idle(2 * P);

      // randomized duty traffic
      for (int i = 0; i < 400; i++) begin
         logic a;
         step(($urandom_range(0, 3) == 0), int'($urandom_range(0, P - 1)), a);
      end
      idle(P);

`ifdef COUNT_CHECK_EN
      #1 chk("count_err_clean", count_err, 1'b0);
      run_until(4);
      idle(2);
      cnt = 7;
      idle(1);
      @(posedge clk);
      #2 chk("count_err_set", count_err, 1'b1);
      idle(5);
      #1 chk("count_err_sticky", count_err, 1'b1);
      #1 reset_n = 1'b0;
      rst_drive = 1'b0;
      #1 chk("count_err_rst", count_err, 1'b0);
      exp_q.delete();
      pend_q.delete();
      act_m = 0;
      idle(1);
      rst_drive = 1'b1;
      idle(2);
`endif

      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_pwm_gen.md
Name: counter_pwm_gen

Overview:
- Downstream consumer of the free-running synchronous up counter; takes its N-bit count value and produces a PWM waveform.
- Duty value arrives over a valid/ready handshake, is held in a one-entry pending buffer, and is applied only at period wrap. This gives glitch-free duty updates.
- Also emits a one-cycle period tick for system timing.

Parameters:
- N, 4, width of count input and duty value; period = 2^N cycles.

Ports:
- clk  input  1  rising-edge clock, same clock as the upstream counter
- reset_n  input  1  asynchronous active-low reset
- count  input  N  current value from the upstream up counter (expected to increment by 1 each cycle, wrapping 2^N-1 -> 0)
- duty_in  input  N  requested duty: number of high cycles per period
- duty_valid  input  1  duty_in is valid
- duty_ready  output  1  pending buffer empty, can accept duty_in
- pwm_out  output  1  registered PWM output
- period_tick  output  1  registered one-cycle pulse per period

Interface: one clock (clk); reset is asynchronous and active-low (reset_n).

Behaviour:
- Reset (reset_n=0, asynchronous, immediate):
  - pwm_out=0, period_tick=0, duty_ready=1.
  - Active duty=0; pending buffer empty; FSM=EMPTY.
- Wrap: wrap = (count == 2^N-1), sampled combinationally each cycle.
- FSM states:
  - EMPTY: pending buffer empty; duty_ready=1.
  - FULL: pending buffer holds a value; duty_ready=0.
- Transfer: accept = duty_valid & duty_ready. duty_ready is a registered function of state only; there is no combinational path from duty_valid.
- EMPTY transitions:
  - accept: capture duty_in into pending; go to FULL.
  - no accept: stay in EMPTY.
- FULL transitions:
  - wrap: active <= pending; go to EMPTY. duty_ready rises the cycle after wrap.
  - no wrap: stay in FULL.
- Accept in the same cycle as wrap (state EMPTY): value goes to pending, not active. It takes effect at the following wrap, so one extra period of latency.
- Multiple accepts within one period: impossible. The second writer waits on ready.
- pwm_out: registered, pwm_out <= (count < active) as an unsigned compare, evaluated with the active value as of that cycle. Latency is 1 cycle from count to pwm_out.
- Newly loaded active: the register updates at the same edge as the wrap, so the compare for count=0 in the next period already uses the new duty.
- Duty boundaries:
  - duty=0: pwm_out constantly 0.
  - duty=2^N-1: high for 2^N-1 of 2^N cycles; 100% is not representable.
- period_tick: registered, period_tick <= wrap. High for exactly one cycle, the cycle in which pwm_out reflects count=2^N-1.
- Reset mid-operation: any pending value is discarded, and outputs return to reset values immediately.
- The block does not check count continuity; see Optional Feature.

Optional Feature:
- Macro: COUNT_CHECK_EN.
- When defined:
  - Adds output port count_err (1 bit) and an internal prev_count register plus first-sample flag.
  - After the first post-reset cycle, count_err is set when count != (prev_count+1) mod 2^N.
  - count_err is sticky until reset; reset value 0.
- When undefined: port, registers and logic are absent; the block is otherwise identical.

Decomposition:
- Package pwm_pkg:
  - buf_state_t enum {EMPTY, FULL}.
  - Localparams for the reset values of active/pending (0).
- Sub-module duty_buffer: holds the FSM, pending and active registers, and the handshake. Inputs are wrap, duty_in and duty_valid; outputs are active and duty_ready.
- Top level contains the compare, pwm/tick registers, and the optional checker.

Test Plan (N=4, count driven as a free-running 0..15 counter):
- Reset asserted mid-period with pending FULL -> immediately pwm_out=0, period_tick=0, duty_ready=1; next period pwm stays 0 (active=0).
- Write duty=4 at count=7 -> duty_ready=0 from next cycle; after wrap, pwm_out high for outputs of count 0..3 (4 cycles, 1-cycle delayed); duty_ready=1 the cycle after wrap.
- Write duty=0 then duty=15 on successive periods -> period of constant 0, then 15 high cycles and 1 low; period_tick pulses once per 16 cycles.
- Back-to-back valid with duty=3 then duty=9 at count=2 -> 3 accepted, 9 held (ready=0) until cycle after wrap, then accepted; 3 applies next period, 9 the period after.
- Accept duty=6 exactly at count=15 in EMPTY -> next period still old duty; period after that shows 6 high cycles.
- COUNT_CHECK_EN: count sequence 4,5,7 -> count_err=1 one cycle after 7 sampled, remains 1 until reset_n=0.
